// File: rtl/eventually_monitor.sv
// Multi-channel bounded/unbounded eventually checker for emulation builds.
// Each channel arms on a trigger and expects its event inside a cycle window.
module eventually_monitor #(
  parameter int NCH     = 4,
  parameter int CW      = 8,
  parameter int MIN_DLY = 2,
  parameter int MAX_DLY = 5,
  parameter int STRONG  = 1,
  parameter int SCW     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NCH-1:0]   arm,
  input  logic [NCH-1:0]   evt,
  input  logic             eot,
  output logic [NCH-1:0]   busy,
  output logic [NCH-1:0]   pass,
  output logic [NCH-1:0]   fail,
  output logic [2*NCH-1:0] fail_cause,
  output logic [SCW-1:0]   pass_cnt,
  output logic [SCW-1:0]   fail_cnt
);

  typedef enum logic {IDLE, WAIT} st_t;

  localparam logic [CW-1:0]  MIN_C = CW'(MIN_DLY);
  localparam logic [CW-1:0]  MAX_C = CW'(MAX_DLY);
  localparam int             PW    = $clog2(NCH + 1);
  localparam int             SW    = SCW + PW;
  localparam logic [SCW-1:0] TOP   = {SCW{1'b1}};

  st_t            st    [NCH];
  st_t            st_n  [NCH];
  logic [CW-1:0]  cnt   [NCH];
  logic [CW-1:0]  cnt_n [NCH];
  logic [CW-1:0]  dn    [NCH];

  logic [NCH-1:0]   pass_n;
  logic [NCH-1:0]   fail_n;
  logic [2*NCH-1:0] cause_n;
  logic [PW-1:0]    np;
  logic [PW-1:0]    nf;
  logic [SW-1:0]    psum;
  logic [SW-1:0]    fsum;
  logic [SCW-1:0]   pc_n;
  logic [SCW-1:0]   fc_n;

  // elapsed delay if this edge resolves; saturates for the unbounded case
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      dn[c] = (&cnt[c]) ? cnt[c] : cnt[c] + CW'(1);
    end
  end

  always_comb begin
    pass_n  = '0;
    fail_n  = '0;
    cause_n = fail_cause;
    for (int c = 0; c < NCH; c++) begin
      st_n[c]  = st[c];
      cnt_n[c] = cnt[c];
      if (st[c] == IDLE) begin
        if (arm[c] && !eot) begin
          st_n[c]  = WAIT;
          cnt_n[c] = '0;
        end
      end else begin
        st_n[c] = IDLE;
        if (evt[c] && dn[c] < MIN_C) begin
          fail_n[c]        = 1'b1;
          cause_n[2*c +: 2] = 2'b01;
        end else if (evt[c] &&
                     (MAX_DLY == 0 || dn[c] <= MAX_C)) begin
          pass_n[c] = 1'b1;
        end else if (eot) begin
          if (STRONG != 0) begin
            fail_n[c]        = 1'b1;
            cause_n[2*c +: 2] = 2'b11;
          end else begin
            pass_n[c] = 1'b1;
          end
        end else if (MAX_DLY != 0 && dn[c] == MAX_C) begin
          fail_n[c]        = 1'b1;
          cause_n[2*c +: 2] = 2'b10;
        end else begin
          st_n[c]  = WAIT;
          cnt_n[c] = dn[c];
        end
      end
    end
  end

  always_comb begin
    np = '0;
    nf = '0;
    for (int c = 0; c < NCH; c++) begin
      np = np + PW'(pass_n[c]);
      nf = nf + PW'(fail_n[c]);
    end
    psum = SW'(pass_cnt) + SW'(np);
    fsum = SW'(fail_cnt) + SW'(nf);
    pc_n = (psum > SW'(TOP)) ? TOP : psum[SCW-1:0];
    fc_n = (fsum > SW'(TOP)) ? TOP : fsum[SCW-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < NCH; c++) begin
        st[c]  <= IDLE;
        cnt[c] <= '0;
      end
      pass       <= '0;
      fail       <= '0;
      fail_cause <= '0;
      pass_cnt   <= '0;
      fail_cnt   <= '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        st[c]  <= st_n[c];
        cnt[c] <= cnt_n[c];
      end
      pass       <= pass_n;
      fail       <= fail_n;
      fail_cause <= cause_n;
      pass_cnt   <= pc_n;
      fail_cnt   <= fc_n;
    end
  end

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      busy[c] = (st[c] == WAIT);
    end
  end

endmodule
